// File: rtl/risc_v_mike_pkg.sv
// Shared core types plus writeback-controller additions.
// Also hosts the common flop macro, async active-low flavour.
`ifndef MIKE_FF_RST_N
`define MIKE_FF_RST_N(q, d, rv, clk, rst_n) \
    always_ff @(posedge clk or negedge rst_n) \
        if (!rst_n) q <= rv; \
        else q <= d;
`endif

package risc_v_mike_pkg;

    localparam int DATA_32_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_DEPTH_DEF = 4;

    typedef logic [REG_ADDR_W-1:0] t_register_addr;

    typedef struct packed {
        t_register_addr         addr;
        logic [DATA_32_W-1:0]   data;
    } t_wb_entry;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } t_wb_src;

endpackage

// File: rtl/risc_v_mike_wb_ctrl_if.sv
// Result handshake from an execution unit into writeback.
interface risc_v_mike_wb_ctrl_if
    import risc_v_mike_pkg::*;
#(
    parameter int DATA_W = DATA_32_W
);
    logic                valid;
    logic                ready;
    t_register_addr      addr;
    logic [DATA_W-1:0]   data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/risc_v_mike_wb_fifo.sv
// Pending-write FIFO: storage, pointers, occupancy.
// Storage is exported so the top can forward from it.
module risc_v_mike_wb_fifo
    import risc_v_mike_pkg::*;
#(
    parameter  int DATA_W = DATA_32_W,
    parameter  int DEPTH  = WB_DEPTH_DEF,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  t_register_addr      push_addr,
    input  logic [DATA_W-1:0]   push_data,
    input  logic                pop,
    output t_register_addr      head_addr,
    output logic [DATA_W-1:0]   head_data,
    output t_register_addr      ent_addr [DEPTH],
    output logic [DATA_W-1:0]   ent_data [DEPTH],
    output logic [PW-1:0]       rd_ptr,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_d = pop  ? rd_ptr + PW'(1) : rd_ptr;
        count_d  = count + CW'(push) - CW'(pop);
    end

    `MIKE_FF_RST_N(wr_ptr, wr_ptr_d, '0, clk, rst)
    `MIKE_FF_RST_N(rd_ptr, rd_ptr_d, '0, clk, rst)
    `MIKE_FF_RST_N(count,  count_d,  '0, clk, rst)

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else if (push) begin
            ent_addr[wr_ptr] <= push_addr;
            ent_data[wr_ptr] <= push_data;
        end
    end

    assign head_addr = ent_addr[rd_ptr];
    assign head_data = ent_data[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
endmodule

// File: rtl/risc_v_mike_wb_ctrl.sv
// Writeback controller: round-robin ALU/LSU arbitration,
// pending-write FIFO drain and operand forwarding.
module risc_v_mike_wb_ctrl
    import risc_v_mike_pkg::*;
#(
    parameter  int DATA_W   = DATA_32_W,
    parameter  int WB_DEPTH = WB_DEPTH_DEF,
    localparam int PW       = $clog2(WB_DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    risc_v_mike_wb_ctrl_if.slave      alu_wb,
    risc_v_mike_wb_ctrl_if.slave      lsu_wb,
    input  logic                      wb_hold,
    output logic                      reg_file_write,
    output t_register_addr            reg_file_wr_addr,
    output logic [DATA_W-1:0]         reg_file_wr_data,
    input  t_register_addr            fwd_addr_1,
    input  t_register_addr            fwd_addr_2,
    output logic                      fwd_hit_1,
    output logic                      fwd_hit_2,
    output logic [DATA_W-1:0]         fwd_data_1,
    output logic [DATA_W-1:0]         fwd_data_2,
    output logic [CW-1:0]             wb_count,
    output logic                      wb_full,
    output logic                      wb_empty
);
    t_wb_src             last_grant;
    t_wb_src             last_grant_d;
    logic                alu_sel;
    logic                lsu_sel;
    logic                alu_acc;
    logic                lsu_acc;
    logic                push;
    logic                pop;
    t_register_addr      push_addr;
    logic [DATA_W-1:0]   push_data;
    t_register_addr      head_addr;
    logic [DATA_W-1:0]   head_data;
    t_register_addr      ent_addr [WB_DEPTH];
    logic [DATA_W-1:0]   ent_data [WB_DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       idx;

    // On a tie the source that did not win last time gets the slot.
    always_comb begin
        alu_sel = alu_wb.valid &
                  (!lsu_wb.valid | (last_grant == WB_SRC_LSU));
        lsu_sel = lsu_wb.valid &
                  (!alu_wb.valid | (last_grant == WB_SRC_ALU));
        alu_acc = rst & !wb_full & alu_sel;
        lsu_acc = rst & !wb_full & lsu_sel;
        alu_wb.ready = alu_acc;
        lsu_wb.ready = lsu_acc;
        last_grant_d = last_grant;
        push_addr    = '0;
        push_data    = '0;
        unique case (1'b1)
            alu_acc: begin
                last_grant_d = WB_SRC_ALU;
                push_addr    = alu_wb.addr;
                push_data    = alu_wb.data;
            end
            lsu_acc: begin
                last_grant_d = WB_SRC_LSU;
                push_addr    = lsu_wb.addr;
                push_data    = lsu_wb.data;
            end
            default: ;
        endcase
        // x0 writes are consumed but never stored.
        push = (alu_acc | lsu_acc) & (push_addr != '0);
    end

    `MIKE_FF_RST_N(last_grant, last_grant_d, WB_SRC_ALU, clk, rst)

    assign pop = !wb_empty & !wb_hold;

    risc_v_mike_wb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (WB_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (push_addr),
        .push_data (push_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .rd_ptr    (rd_ptr),
        .count     (wb_count),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    assign reg_file_write   = pop;
    assign reg_file_wr_addr = wb_empty ? '0 : head_addr;
    assign reg_file_wr_data = wb_empty ? '0 : head_data;

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        fwd_hit_1  = 1'b0;
        fwd_hit_2  = 1'b0;
        fwd_data_1 = '0;
        fwd_data_2 = '0;
        idx        = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < wb_count) begin
                if (fwd_addr_1 != '0 && ent_addr[idx] == fwd_addr_1) begin
                    fwd_hit_1  = 1'b1;
                    fwd_data_1 = ent_data[idx];
                end
                if (fwd_addr_2 != '0 && ent_addr[idx] == fwd_addr_2) begin
                    fwd_hit_2  = 1'b1;
                    fwd_data_2 = ent_data[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_risc_v_mike_wb_ctrl.sv
// Bench for risc_v_mike_wb_ctrl: queue-based reference model,
// directed scenarios and randomized traffic.
module tb_risc_v_mike_wb_ctrl;
    import risc_v_mike_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    risc_v_mike_wb_ctrl_if #(.DATA_W(DW)) alu_if ();
    risc_v_mike_wb_ctrl_if #(.DATA_W(DW)) lsu_if ();

    logic            wb_hold;
    logic            reg_file_write;
    t_register_addr  reg_file_wr_addr;
    logic [DW-1:0]   reg_file_wr_data;
    t_register_addr  fwd_addr_1;
    t_register_addr  fwd_addr_2;
    logic            fwd_hit_1;
    logic            fwd_hit_2;
    logic [DW-1:0]   fwd_data_1;
    logic [DW-1:0]   fwd_data_2;
    logic [2:0]      wb_count;
    logic            wb_full;
    logic            wb_empty;

    risc_v_mike_wb_ctrl #(.DATA_W(DW), .WB_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_wb           (alu_if),
        .lsu_wb           (lsu_if),
        .wb_hold          (wb_hold),
        .reg_file_write   (reg_file_write),
        .reg_file_wr_addr (reg_file_wr_addr),
        .reg_file_wr_data (reg_file_wr_data),
        .fwd_addr_1       (fwd_addr_1),
        .fwd_addr_2       (fwd_addr_2),
        .fwd_hit_1        (fwd_hit_1),
        .fwd_hit_2        (fwd_hit_2),
        .fwd_data_1       (fwd_data_1),
        .fwd_data_2       (fwd_data_2),
        .wb_count         (wb_count),
        .wb_full          (wb_full),
        .wb_empty         (wb_empty)
    );

    // Reference model: pending writes in arrival order.
    t_wb_entry q[$];
    bit        last_lsu;
    int        n_chk  = 0;
    int        n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_alu_rdy();
        return rst === 1'b1 && q.size() < DEPTH && alu_if.valid === 1'b1 &&
               (lsu_if.valid !== 1'b1 || last_lsu);
    endfunction

    function automatic bit m_lsu_rdy();
        return rst === 1'b1 && q.size() < DEPTH && lsu_if.valid === 1'b1 &&
               (alu_if.valid !== 1'b1 || !last_lsu);
    endfunction

    task automatic compare();
        int n;
        bit h1, h2;
        logic [31:0] d1, d2;
        n = q.size();
        chk("alu_ready", alu_if.ready, m_alu_rdy());
        chk("lsu_ready", lsu_if.ready, m_lsu_rdy());
        chk("count", wb_count, n);
        chk("full", wb_full, n == DEPTH);
        chk("empty", wb_empty, n == 0);
        chk("write", reg_file_write, n > 0 && !wb_hold);
        if (n > 0) begin
            chk("wr_addr", reg_file_wr_addr, q[0].addr);
            chk("wr_data", reg_file_wr_data, q[0].data);
        end else begin
            chk("wr_addr", reg_file_wr_addr, 0);
            chk("wr_data", reg_file_wr_data, 0);
        end
        h1 = 0; h2 = 0; d1 = 0; d2 = 0;
        foreach (q[i]) begin
            if (fwd_addr_1 != 0 && q[i].addr == fwd_addr_1) begin
                h1 = 1; d1 = q[i].data;
            end
            if (fwd_addr_2 != 0 && q[i].addr == fwd_addr_2) begin
                h2 = 1; d2 = q[i].data;
            end
        end
        chk("fwd_hit_1", fwd_hit_1, h1);
        chk("fwd_data_1", fwd_data_1, d1);
        chk("fwd_hit_2", fwd_hit_2, h2);
        chk("fwd_data_2", fwd_data_2, d2);
    endtask

    task automatic tick();
        bit wr, ra, rl;
        @(negedge clk);
        compare();
        @(posedge clk);
        if (rst === 1'b1) begin
            wr = q.size() > 0 && !wb_hold;
            ra = m_alu_rdy();
            rl = m_lsu_rdy();
            if (wr) void'(q.pop_front());
            if (ra) begin
                if (alu_if.addr != 0)
                    q.push_back('{addr: alu_if.addr, data: alu_if.data});
                last_lsu = 0;
            end else if (rl) begin
                if (lsu_if.addr != 0)
                    q.push_back('{addr: lsu_if.addr, data: lsu_if.data});
                last_lsu = 1;
            end
        end
        #1;
    endtask

    task automatic drive(bit av, logic [4:0] aa, logic [31:0] ad,
                         bit lv, logic [4:0] la, logic [31:0] ld, bit h);
        alu_if.valid = av; alu_if.addr = aa; alu_if.data = ad;
        lsu_if.valid = lv; lsu_if.addr = la; lsu_if.data = ld;
        wb_hold = h;
    endtask

    task automatic idle(bit h);
        drive(0, 0, 0, 0, 0, 0, h);
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_write"}, reg_file_write, 0);
        chk({tag, "_count"}, wb_count, 0);
        chk({tag, "_empty"}, wb_empty, 1);
        chk({tag, "_full"}, wb_full, 0);
        chk({tag, "_alu_ready"}, alu_if.ready, 0);
        chk({tag, "_lsu_ready"}, lsu_if.ready, 0);
        chk({tag, "_wr_addr"}, reg_file_wr_addr, 0);
        chk({tag, "_wr_data"}, reg_file_wr_data, 0);
        chk({tag, "_fwd_hit_1"}, fwd_hit_1, 0);
    endtask

    task automatic async_reset(string tag);
        rst = 1'b0;
        q.delete();
        last_lsu = 0;
        drive(1, 5'd3, 32'h55, 1, 5'd4, 32'h66, 0);
        fwd_addr_1 = 5'd1;
        #1;
        reset_checks(tag);
        idle(0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lsu_win;

    initial begin
        last_lsu = 0;
        idle(0);
        fwd_addr_1 = 0;
        fwd_addr_2 = 0;

        // Reset state, with a source requesting to show ready stays low.
        alu_if.valid = 1;
        fwd_addr_1 = 5'd1;
        #12;
        reset_checks("rst");
        idle(0);
        fwd_addr_1 = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU write to x5.
        drive(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0);
        #1;
        chk("t1_alu_ready", alu_if.ready, 1);
        tick();
        idle(0);
        chk("t1_write", reg_file_write, 1);
        chk("t1_addr", reg_file_wr_addr, 5);
        chk("t1_data", reg_file_wr_data, 32'h1234_5678);
        tick();
        chk("t1_empty", wb_empty, 1);

        // Both sources valid: grants alternate starting with LSU.
        lsu_win = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            drive(1, 5'(k + 1), 32'hA0 + k, 1, 5'(k + 1), 32'hB0 + k, 0);
            #1;
            chk("t2_lsu_grant", lsu_if.ready, lsu_win[k]);
            chk("t2_alu_grant", alu_if.ready, !lsu_win[k]);
            if (k > 0)
                chk("t2_drain", reg_file_wr_data,
                    lsu_win[k-1] ? 32'hB0 + k - 1 : 32'hA0 + k - 1);
            tick();
        end
        idle(0);
        repeat (3) tick();

        // Hold with five pushes: fourth fills the FIFO.
        for (int k = 0; k < 5; k++) begin
            drive(1, 5'(10 + k), 32'hC0 + k, 0, 0, 0, 1);
            #1;
            chk("t3_ready", alu_if.ready, k < 4);
            if (k < 4) tick();
        end
        chk("t3_full", wb_full, 1);
        wb_hold = 0;
        #1;
        chk("t3_head", reg_file_wr_addr, 10);
        chk("t3_write", reg_file_write, 1);
        tick();
        chk("t3_fifth_ready", alu_if.ready, 1);
        tick();
        idle(0);
        repeat (5) tick();

        // Forwarding returns the youngest pending value.
        drive(1, 5'd7, 32'hA, 0, 0, 0, 1);
        tick();
        drive(1, 5'd7, 32'hB, 0, 0, 0, 1);
        tick();
        idle(1);
        fwd_addr_1 = 5'd7;
        fwd_addr_2 = 5'd0;
        #1;
        chk("t4_hit_1", fwd_hit_1, 1);
        chk("t4_data_1", fwd_data_1, 32'hB);
        chk("t4_hit_2", fwd_hit_2, 0);
        chk("t4_data_2", fwd_data_2, 0);
        tick();
        wb_hold = 0;
        repeat (3) tick();
        fwd_addr_1 = 0;

        // x0 write is accepted but not stored.
        drive(1, 5'd0, 32'hDEAD, 0, 0, 0, 0);
        #1;
        chk("t5_ready", alu_if.ready, 1);
        tick();
        idle(0);
        chk("t5_count", wb_count, 0);
        chk("t5_write", reg_file_write, 0);
        tick();

        // Reset mid-cycle with three pending entries.
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(k + 1), 32'hE0 + k, 0, 0, 0, 1);
            tick();
        end
        idle(1);
        chk("t6_count_pre", wb_count, 3);
        #1;
        async_reset("t6");
        wb_hold = 0;
        repeat (3) begin
            tick();
            chk("t6_no_write", reg_file_write, 0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 9) < 6,
                  ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  $urandom,
                  $urandom_range(0, 3) == 0);
            fwd_addr_1 = 5'($urandom_range(0, 7));
            fwd_addr_2 = 5'($urandom_range(0, 7));
            if (c == 1500) begin
                #2;
                async_reset("rnd_rst");
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/risc_v_mike_wb_ctrl.md
# risc_v_mike_wb_ctrl

Writeback controller on the write side of the register file. It accepts results from the ALU and LSU through valid/ready handshakes and arbitrates between them round-robin. It queues the results in a small FIFO and drains one entry per cycle into the register file write port (reg_file_write / reg_file_wr_addr / reg_file_wr_data). It also forwards pending, not-yet-written values to the two operand read ports.

## Interface
- DATA_W, default DATA_32_W: result data width.
- WB_DEPTH, default 4: pending-write FIFO entries; power of 2, at least 2.
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- alu_wb_valid / alu_wb_ready  in / out  1 each  ALU result handshake.
- alu_wb_addr  in  t_register_addr  ALU destination register.
- alu_wb_data  in  DATA_W  ALU result.
- lsu_wb_valid / lsu_wb_ready  in / out  1 each  LSU load-data handshake.
- lsu_wb_addr  in  t_register_addr  LSU destination register.
- lsu_wb_data  in  DATA_W  load result.
- wb_hold  in  1  freezes draining; the register file port is borrowed.
- reg_file_write  out  1  write strobe to the register file.
- reg_file_wr_addr  out  t_register_addr  write address.
- reg_file_wr_data  out  DATA_W  write data.
- fwd_addr_1, fwd_addr_2  in  t_register_addr  rs1/rs2 lookup addresses.
- fwd_hit_1, fwd_hit_2  out  1  a pending write to that address exists.
- fwd_data_1, fwd_data_2  out  DATA_W  youngest pending value for that address.
- wb_count  out  $clog2(WB_DEPTH)+1  occupancy.
- wb_full, wb_empty  out  1  occupancy flags.

## Operation
- Transfer: src_valid & src_ready at a rising edge.
- Ready rule: at most one source is granted per cycle, and only when !wb_full. Ready is never asserted when full, even if a pop happens the same cycle.
- Ready may depend on valid.
- Arbitration state last_grant ∈ {ALU, LSU}; reset value ALU, so LSU wins the first tie.
  - Both valid: grant the source not equal to last_grant.
  - One valid: grant that source.
  - last_grant updates only on an accepted transfer.
- Address 0 write: the transfer is accepted (ready per rules above), no entry is pushed, and last_grant still updates.
- Drain: reg_file_write = !wb_empty & !wb_hold.
  - reg_file_wr_addr/data show the FIFO head whenever non-empty.
  - The head pops at the edge where reg_file_write = 1.
- Push and pop may occur in the same cycle; count is unchanged.
- Forwarding: purely combinational over valid FIFO entries.
  - Hit when an entry's address equals fwd_addr_n and fwd_addr_n != 0.
  - Data comes from the youngest match.
  - No hit: fwd_data_n = 0.
  - The incoming same-cycle transfer is not forwarded.
- Pointers wrap modulo WB_DEPTH. Full when count == WB_DEPTH; empty when count == 0.

## Timing
- Latency: a push at edge N appears at the head in cycle N+1. The register file is written at edge N+1 if the FIFO was empty and wb_hold = 0.
- Throughput: 1 write per cycle sustained.
- Reset values (asynchronous, immediate):
  - Pointers 0, count 0, wb_empty = 1, wb_full = 0.
  - reg_file_write = 0; reg_file_wr_addr/data = 0; entry storage 0.
  - Both readys 0 while rst is asserted. After release, readys follow the grant rules.
  - fwd_hit = 0.
- Reset mid-operation drops all pending writes.
- wb_hold asserted: the head is stable and count does not decrease; pushes continue until full.

## Structure
- Add to risc_v_mike_pkg:
  - t_wb_entry (struct: t_register_addr addr, logic [DATA_32_W-1:0] data).
  - t_wb_src enum {WB_SRC_ALU, WB_SRC_LSU}.
  - WB_DEPTH_DEF = 4.
- Flops use the shared `MIKE_FF_RST style macro, extended to an active-low asynchronous variant.
- One sub-module is natural: risc_v_mike_wb_fifo (storage, pointers, count, full/empty). Arbitration and forwarding stay in the top.

## Test plan
- After reset, ALU writes x5 = 0x1234_5678 → reg_file_write high one cycle later with addr 5 and that data; wb_empty returns to 1.
- ALU and LSU valid together for 4 cycles (x1..x4) → grants alternate LSU, ALU, LSU, ALU; writes drain in grant order, 1 per cycle.
- wb_hold = 1 with 5 ALU pushes → 4 accepted, wb_full = 1, alu_wb_ready = 0; release hold → 4 writes in order, then the fifth is accepted.
- Pending x7 = 0xA, then x7 = 0xB, under hold; fwd_addr_1 = 7 → fwd_hit_1 = 1, fwd_data_1 = 0xB; fwd_addr_2 = 0 → fwd_hit_2 = 0.
- Write to x0 → ready = 1, count stays 0, reg_file_write never asserts.
- 3 entries pending, rst pulsed low mid-cycle → outputs zero immediately; no writes after release.
